direction_cmd_conditioner: RTL and testbench

//  Upstream stage of the semi-auto crossroad FSM: turns the four raw direction buttons into clean one-hot

---
 rtl/dir_cmd_pkg.sv | 36 +++
 rtl/btn_debounce.sv | 56 +++++
 rtl/direction_cmd_conditioner.sv | 140 ++++++++++++++
 tb/tb_direction_cmd_conditioner.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dir_cmd_pkg.sv
// ============================================================================
// Package : dir_cmd_pkg
// Command codes and FSM state encoding for the direction command conditioner.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package dir_cmd_pkg;

  localparam logic [1:0] CMD_LEFT     = 2'b00;
  localparam logic [1:0] CMD_RIGHT    = 2'b01;
  localparam logic [1:0] CMD_STRAIGHT = 2'b10;
  localparam logic [1:0] CMD_BACK     = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_HOLD     = 2'b01,
    ST_REL_WAIT = 2'b10
  } state_t;

  // Bit order of the one-hot vector is {back, straight, right, left}.
  function automatic logic [1:0] onehot_to_cmd(input logic [3:0] oh);
    logic [1:0] code;
    code = CMD_LEFT;
    case (oh)
      4'b0010: code = CMD_RIGHT;
      4'b0100: code = CMD_STRAIGHT;
      4'b1000: code = CMD_BACK;
      default: code = CMD_LEFT;
    endcase
    return code;
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module : btn_debounce
// Two-flop synchroniser, ms-tick debounce counter and one-cycle rise detect.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module btn_debounce #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ms_tick,
  input  logic i_btn,
  output logic o_stable,
  output logic o_rise
);

  localparam int              c_cw      = $clog2(DEBOUNCE_MS + 1);
  localparam logic [c_cw-1:0] c_db_term = c_cw'(DEBOUNCE_MS);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_stable;
  logic            r_stable_d;
  logic [c_cw-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= i_btn;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      // Any return to the stable level restarts the qualification window.
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == c_db_term) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else if (i_ms_tick) begin
        r_cnt <= r_cnt + c_cw'(1);
      end
    end
  end

  assign o_stable = r_stable;
  assign o_rise   = r_stable & ~r_stable_d;

endmodule

`default_nettype wire

// File: rtl/direction_cmd_conditioner.sv
// ============================================================================
// Module : direction_cmd_conditioner
// Turns four raw direction buttons into held, one-hot command levels.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module direction_cmd_conditioner
  import dir_cmd_pkg::*;
#(
  parameter int TICK_DIV    = 100_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int HOLD_MS     = 40
) (
  input  logic       i_sys_clk,
  input  logic       i_rst_n,
  input  logic       i_enable,
  input  logic       i_btn_left,
  input  logic       i_btn_right,
  input  logic       i_btn_straight,
  input  logic       i_btn_back,
  output logic       o_turn_left,
  output logic       o_turn_right,
  output logic       o_go_straight,
  output logic       o_go_back,
  output logic [1:0] o_cmd_code,
  output logic       o_conflict
);

  localparam int              c_pw        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int              c_hw        = $clog2(HOLD_MS + 1);
  localparam logic [c_pw-1:0] c_presc_top = c_pw'(TICK_DIV - 1);
  localparam logic [c_hw-1:0] c_hold_term = c_hw'(HOLD_MS);

  logic [c_pw-1:0] r_presc;
  logic            w_ms_tick;
  logic [3:0]      w_raw;
  logic [3:0]      w_stable;
  logic [3:0]      w_rise;
  logic            w_any_rise;
  logic            w_single;
  logic            w_multi;

  state_t          r_state;
  logic [1:0]      r_code;
  logic [c_hw-1:0] r_hold;
  logic [3:0]      r_cmd_oh;
  logic            r_conflict;

  assign w_ms_tick = (r_presc == c_presc_top);

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_presc <= '0;
    end else if (w_ms_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + c_pw'(1);
    end
  end

  assign w_raw = {i_btn_back, i_btn_straight, i_btn_right, i_btn_left};

  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_MS (DEBOUNCE_MS)
    ) u_btn_debounce (
      .i_clk     (i_sys_clk),
      .i_rst_n   (i_rst_n),
      .i_ms_tick (w_ms_tick),
      .i_btn     (w_raw[gi]),
      .o_stable  (w_stable[gi]),
      .o_rise    (w_rise[gi])
    );
  end

  assign w_any_rise = |w_rise;
  assign w_single   = w_any_rise && ((w_rise & (w_rise - 4'd1)) == 4'd0);
  assign w_multi    = w_any_rise && !w_single;

  // The rising one-hot vector is stored directly so the outputs come from flops.
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_code     <= CMD_LEFT;
      r_hold     <= '0;
      r_cmd_oh   <= 4'b0000;
      r_conflict <= 1'b0;
    end else begin
      r_conflict <= 1'b0;
      if (!i_enable) begin
        r_state  <= ST_IDLE;
        r_hold   <= '0;
        r_cmd_oh <= 4'b0000;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_single) begin
              r_code   <= onehot_to_cmd(w_rise);
              r_cmd_oh <= w_rise;
              r_hold   <= '0;
              r_state  <= ST_HOLD;
            end else if (w_multi) begin
              r_conflict <= 1'b1;
            end
          end
          ST_HOLD: begin
            if (r_hold == c_hold_term) begin
              r_hold   <= '0;
              r_cmd_oh <= 4'b0000;
              r_state  <= ST_REL_WAIT;
            end else if (w_ms_tick) begin
              r_hold <= r_hold + c_hw'(1);
            end
          end
          ST_REL_WAIT: begin
            r_cmd_oh <= 4'b0000;
            if (w_stable == 4'b0000) begin
              r_state <= ST_IDLE;
            end
          end
          default: begin
            r_cmd_oh <= 4'b0000;
            r_state  <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign o_turn_left   = r_cmd_oh[0];
  assign o_turn_right  = r_cmd_oh[1];
  assign o_go_straight = r_cmd_oh[2];
  assign o_go_back     = r_cmd_oh[3];
  assign o_cmd_code    = r_code;
  assign o_conflict    = r_conflict;

endmodule

`default_nettype wire

// File: tb/tb_direction_cmd_conditioner.sv
// ============================================================================
// Module : tb_direction_cmd_conditioner
// Self-checking bench: press vectors table, output-window scoreboard, corner sequences.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_direction_cmd_conditioner;

  localparam int TICK_DIV    = 4;
  localparam int DEBOUNCE_MS = 3;
  localparam int HOLD_MS     = 5;
  // Held window: HOLD_MS ticks plus tick phase plus the terminal cycle.
  localparam int LEN_LO = HOLD_MS * TICK_DIV - 2;
  localparam int LEN_HI = HOLD_MS * TICK_DIV + 1;
  // Press to output: 2 sync + DEBOUNCE_MS ticks (+phase) + flip + accept.
  localparam int LAT_LO = DEBOUNCE_MS * TICK_DIV + 1;
  localparam int LAT_HI = DEBOUNCE_MS * TICK_DIV + 4;
  localparam int GAP    = 40;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] btn;
  logic       turn_left, turn_right, go_straight, go_back, conflict;
  logic [1:0] cmd_code;
  logic [3:0] outs;

  assign outs = {go_back, go_straight, turn_right, turn_left};

  always #5 clk = ~clk;

  direction_cmd_conditioner #(
    .TICK_DIV    (TICK_DIV),
    .DEBOUNCE_MS (DEBOUNCE_MS),
    .HOLD_MS     (HOLD_MS)
  ) dut (
    .i_sys_clk      (clk),
    .i_rst_n        (rst_n),
    .i_enable       (en),
    .i_btn_left     (btn[0]),
    .i_btn_right    (btn[1]),
    .i_btn_straight (btn[2]),
    .i_btn_back     (btn[3]),
    .o_turn_left    (turn_left),
    .o_turn_right   (turn_right),
    .o_go_straight  (go_straight),
    .o_go_back      (go_back),
    .o_cmd_code     (cmd_code),
    .o_conflict     (conflict)
  );

  typedef struct {
    logic [3:0] outs;
    logic [1:0] code;
    int         len;
  } ev_t;

  typedef struct {
    string      name;
    logic [3:0] btn;
    int         cycles;
    bit         en;
    bit         acc;
    logic [1:0] code;
    int         conf;
  } vec_t;

  ev_t        obs_q[$];
  logic [1:0] exp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_conflict = 0;
  int         n_inv    = 0;

  task automatic chk(input string name, input bit ok, input int act, input int exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Monitor: records every contiguous window of a held command output.
  initial begin
    ev_t        cur;
    logic [3:0] prev;
    prev = 4'b0000;
    cur  = '{outs: 4'b0000, code: 2'b00, len: 0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        if (prev != 4'b0000) obs_q.push_back(cur);
        prev = 4'b0000;
      end else begin
        if (conflict) n_conflict++;
        if ($countones(outs) > 1) n_inv++;
        if (outs != 4'b0000) begin
          if (prev == 4'b0000) begin
            cur.outs = outs;
            cur.code = cmd_code;
            cur.len  = 1;
          end else begin
            cur.len++;
            if (outs != cur.outs) n_inv++;
          end
        end else if (prev != 4'b0000) begin
          obs_q.push_back(cur);
        end
        prev = outs;
      end
    end
  end

  task automatic score(input string tag);
    logic [1:0] e;
    logic [3:0] e_oh;
    ev_t        ev;
    while (exp_q.size() > 0) begin
      e    = exp_q.pop_front();
      e_oh = 4'b0001 << e;
      if (obs_q.size() == 0) begin
        chk({tag, "_missing_cmd"}, 1'b0, 0, 1);
      end else begin
        ev = obs_q.pop_front();
        chk({tag, "_code"}, ev.code == e, int'(ev.code), int'(e));
        chk({tag, "_onehot"}, ev.outs == e_oh, int'(ev.outs), int'(e_oh));
        chk({tag, "_hold_len"}, ev.len >= LEN_LO && ev.len <= LEN_HI, ev.len, HOLD_MS * TICK_DIV);
      end
    end
    chk({tag, "_extra_cmd"}, obs_q.size() == 0, obs_q.size(), 0);
    obs_q.delete();
  endtask

  task automatic wait_outs(output int k);
    k = 0;
    while (outs == 4'b0000 && k < 60) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[9];
    int   c0;
    int   k;
    int   nz;

    vecs[0] = '{"left_press",     4'b0001, 40,  1'b1, 1'b1, 2'b00, 0};
    vecs[1] = '{"right_glitch",   4'b0010, 6,   1'b1, 1'b0, 2'b00, 0};
    vecs[2] = '{"straight_back",  4'b1100, 40,  1'b1, 1'b0, 2'b00, 1};
    vecs[3] = '{"back_alone",     4'b1000, 40,  1'b1, 1'b1, 2'b11, 0};
    vecs[4] = '{"left_long_hold", 4'b0001, 100, 1'b1, 1'b1, 2'b00, 0};
    vecs[5] = '{"left_repress",   4'b0001, 40,  1'b1, 1'b1, 2'b00, 0};
    vecs[6] = '{"right_press",    4'b0010, 40,  1'b1, 1'b1, 2'b01, 0};
    vecs[7] = '{"straight_press", 4'b0100, 40,  1'b1, 1'b1, 2'b10, 0};
    vecs[8] = '{"back_disabled",  4'b1000, 40,  1'b0, 1'b0, 2'b00, 0};

    rst_n = 1'b0;
    en    = 1'b1;
    btn   = 4'b0000;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs == 4'b0000, int'(outs), 0);
    chk("reset_code", cmd_code == 2'b00, int'(cmd_code), 0);
    chk("reset_conflict", conflict == 1'b0, int'(conflict), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      c0  = n_conflict;
      en  = vecs[i].en;
      btn = vecs[i].btn;
      if (vecs[i].acc) exp_q.push_back(vecs[i].code);
      repeat (vecs[i].cycles) @(negedge clk);
      btn = 4'b0000;
      repeat (GAP) @(negedge clk);
      en = 1'b1;
      repeat (2) @(negedge clk);
      score(vecs[i].name);
      chk({vecs[i].name, "_conflicts"}, (n_conflict - c0) == vecs[i].conf, n_conflict - c0, vecs[i].conf);
    end

    // Enable dropped while a command is being held.
    btn = 4'b0001;
    wait_outs(k);
    chk("en_drop_held", outs == 4'b0001, int'(outs), 1);
    repeat (3) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("en_drop_outs", outs == 4'b0000, int'(outs), 0);
    chk("en_drop_code_kept", cmd_code == 2'b00, int'(cmd_code), 0);
    btn = 4'b0000;
    repeat (2) @(negedge clk);
    en = 1'b1;
    nz = 0;
    repeat (GAP) begin
      @(negedge clk);
      if (outs != 4'b0000) nz++;
    end
    chk("reenable_no_press", nz == 0, nz, 0);
    obs_q.delete();

    // Asynchronous reset between clock edges while holding a right command.
    btn = 4'b0010;
    wait_outs(k);
    chk("rst_pre_held", outs == 4'b0010, int'(outs), 2);
    chk("rst_pre_code", cmd_code == 2'b01, int'(cmd_code), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_outs", outs == 4'b0000, int'(outs), 0);
    chk("rst_async_code", cmd_code == 2'b00, int'(cmd_code), 0);
    btn = 4'b0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    obs_q.delete();

    exp_q.push_back(2'b01);
    btn = 4'b0010;
    wait_outs(k);
    chk("rst_rearm_latency", k >= LAT_LO && k <= LAT_HI, k, LAT_LO);
    repeat (GAP) @(negedge clk);
    btn = 4'b0000;
    repeat (GAP) @(negedge clk);
    score("rst_rearm");

    chk("onehot_invariant", n_inv == 0, n_inv, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
